// File: rtl/reg_file_if.sv
// reg_file_if: operand/result bus between an ALU-side master and the
// integer register file.
//
// Signals
//   rs1_addr, rs2_addr : read addresses, sampled every clock edge
//   rd_we, rd_addr,
//   rd_data            : result write, taken on the edge where rd_we=1
//   rs1_data, rs2_data : registered read data, one cycle after the address
//   ready              : level status, high once the register file is cleared
//   dbg_state          : current sequencer state (0 = CLEAR, 1 = RUN)
//
// Handshake semantics: there is no valid/ready pairing on this bus. Reads
// and writes are accepted on every rising edge while ready=1. While ready=0
// the register file ignores writes and returns zero on both read ports, so
// the master must hold off until it sees ready=1.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rd_we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ready;
  logic            dbg_state;

  modport master (
    output rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
    input  rs1_data, rs2_data, ready, dbg_state
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
    output rs1_data, rs2_data, ready, dbg_state
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: integer register file with two registered read ports and one
// write port; x0 reads as zero. After reset a clear sequencer zeroes
// x1..x(NREG-1) one per clock before ready is raised.
//
// Ports
//   clk   : system clock, rising edge active
//   rst_n : asynchronous active-low reset
//   bus   : reg_file_if slave modport (read/write ports, ready, dbg_state)
//
// XLEN and AW must match the parameters of the connected interface.
module reg_file #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e          state_q,   state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            ready_q,   ready_d;
  logic [XLEN-1:0] rs1_q,     rs1_d;
  logic [XLEN-1:0] rs2_q,     rs2_d;

  // Storage has no reset; it is only ever initialised by the clear sequence.
  logic [XLEN-1:0] mem [NREG];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            run_wr;

  // Read mux: x0 is zero, a same-edge write to the same address is
  // forwarded so the reader sees the new value, otherwise the array.
  function automatic logic [XLEN-1:0] sel_read(
    input logic [AW-1:0]   addr,
    input logic            wr_hit,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] mdata
  );
    logic [XLEN-1:0] r;
    if (addr == '0) begin
      r = '0;
    end else if (wr_hit) begin
      r = wdata;
    end else begin
      r = mdata;
    end
    return r;
  endfunction

  // A write to x0 is discarded and therefore never forwarded either.
  assign run_wr = bus.rd_we && (bus.rd_addr != '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    rs1_d     = '0;
    rs2_d     = '0;
    wr_en     = 1'b0;
    wr_addr   = clr_cnt_q;
    wr_data   = '0;

    case (state_q)
      ST_CLEAR: begin
        // rd_we is ignored here; the only writer is the sequencer.
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q;
        wr_data = '0;
        if (clr_cnt_q == '1) begin
          // Last register cleared on this edge; counter never wraps.
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      ST_RUN: begin
        wr_en   = run_wr;
        wr_addr = bus.rd_addr;
        wr_data = bus.rd_data;
        rs1_d   = sel_read(bus.rs1_addr,
                           run_wr && (bus.rd_addr == bus.rs1_addr),
                           bus.rd_data, mem[bus.rs1_addr]);
        rs2_d   = sel_read(bus.rs2_addr,
                           run_wr && (bus.rd_addr == bus.rs2_addr),
                           bus.rd_data, mem[bus.rs2_addr]);
      end

      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = AW'(1);
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= AW'(1);
      ready_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  // While reset is held the state is CLEAR, so only zero can be written;
  // a pending rd_we can never land on the edge after reset asserts.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.rs1_data  = rs1_q;
  assign bus.rs2_data  = rs2_q;
  assign bus.ready     = ready_q;
  assign bus.dbg_state = logic'(state_q);

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  reg_file_if #(.XLEN(XLEN), .AW(AW)) bus ();

  reg_file #(.XLEN(XLEN), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] waddr,
                       input logic [XLEN-1:0] wdata,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.rd_we    = we;
    bus.rd_addr  = waddr;
    bus.rd_data  = wdata;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
  endtask

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops one pair of expected read values and compares both ports.
  task automatic check_reads(input string name);
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    check({name, "_rs1"}, bus.rs1_data, e1);
    check({name, "_rs2"}, bus.rs2_data, e2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd7,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'hFFFFFFFF, 32'h0};
    vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 5'd9,  32'h00000001, 5'd1,  5'd2,  32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd7,  32'hCAFEF00D, 32'hFFFFFFFF};
    vecs[9]  = '{1'b1, 5'd20, 32'h0BADC0DE, 5'd7,  5'd20, 32'hFFFFFFFF, 32'h0BADC0DE};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd20, 32'hCAFEF00D, 32'h0BADC0DE};
    vecs[11] = '{1'b1, 5'd31, 32'h13579BDF, 5'd31, 5'd1,  32'h13579BDF, 32'h0};

    // ---- reset state ----
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    check("rst_ready", {31'b0, bus.ready}, 32'h0);
    check("rst_rs1", bus.rs1_data, 32'h0);
    check("rst_rs2", bus.rs2_data, 32'h0);

    // ---- clear sequence, with a write attempt that must be ignored ----
    drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd5, 5'd31);
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("clr_ready_e%0d", k), {31'b0, bus.ready},
            (k == 31) ? 32'h1 : 32'h0);
      check($sformatf("clr_rs1_e%0d", k), bus.rs1_data, 32'h0);
      check($sformatf("clr_rs2_e%0d", k), bus.rs2_data, 32'h0);
    end

    // First RUN read of x5 / x31: both cleared.
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick();
    check_reads("first_run");

    // ---- table-driven RUN vectors ----
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].a1, vecs[i].a2);
      exp_q.push_back(vecs[i].e1);
      exp_q.push_back(vecs[i].e2);
      tick();
      check_reads($sformatf("vec%0d", i));
    end

    // ---- full sweep: write then read complementary pairs ----
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, AW'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, AW'(i), AW'(32 - i));
      exp_q.push_back(32'(i) * 32'h01010101);
      exp_q.push_back(32'(32 - i) * 32'h01010101);
      tick();
      check_reads($sformatf("sweep%0d", i));
    end

    // ---- asynchronous reset mid-RUN ----
    drive(1'b1, 5'd7, 32'hFFFFFFFF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'hFFFFFFFF);
    tick();
    check_reads("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, bus.ready}, 32'h0);
    check("midrst_rs1", bus.rs1_data, 32'h0);
    check("midrst_rs2", bus.rs2_data, 32'h0);
    // A write held across reset and the following clear must not land.
    drive(1'b1, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd7);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!bus.ready && n < 40) begin
      tick();
      n++;
    end
    check("reclear_latency", 32'(n), 32'd31);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick();
    check_reads("post_reclear_x7");

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file at the opposite end of the ALU operand/result interface.
- Sources the `rs1`/`rs2` operands that ALU units such as `alu_and` consume, and sinks the `rd` result they produce.
- Two registered read ports and one write port; `x0` is hardwired to zero.
- After reset, a clear sequencer zeroes every register before the file reports ready.

Parameters:
- XLEN, 32, data width of each register and of each port.
- AW, 5, address width; number of registers NREG = 2**AW.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rd_we  input  1  write enable for the result.
- rd_addr  input  AW  write address.
- rd_data  input  XLEN  write data (ALU `rd`).
- rs1_data  output  XLEN  registered read data, port 1 (ALU `rs1`).
- rs2_data  output  XLEN  registered read data, port 2 (ALU `rs2`).
- ready  output  1  high once the clear sequence has completed.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Register array: has no reset of its own. It is initialised only by the clear sequencer.
- Reset values (applied asynchronously while `rst_n`=0):
  - state=CLEAR, clr_cnt=1.
  - ready=0, rs1_data=0, rs2_data=0.
- State CLEAR:
  - Each posedge writes 0 to reg[clr_cnt], then clr_cnt++.
  - The posedge that writes reg[NREG-1] moves to RUN and sets ready=1.
  - ready therefore rises on the (NREG-1)th posedge after `rst_n` deasserts: 31 edges with defaults.
  - rd_we is ignored. rs1_data and rs2_data are driven to 0 every edge.
- State RUN, write: at posedge, if rd_we=1 and rd_addr!=0, then reg[rd_addr] <= rd_data. Writes to address 0 are discarded.
- State RUN, read (1-cycle latency):
  - At each posedge, rsN_data <= value for rsN_addr sampled at that edge.
  - Priority order:
    (a) rsN_addr==0 -> 0;
    (b) rd_we=1, rd_addr==rsN_addr, rd_addr!=0 -> rd_data (write-through bypass, new value);
    (c) otherwise reg[rsN_addr].
- Port independence: both read ports are fully independent. rs1_addr==rs2_addr returns the same value on both ports.
- Write-then-read: a read at edge N+1 after a write at edge N returns the written value.
- Reset mid-operation: asserting `rst_n` in any state immediately returns to CLEAR and drops ready and the outputs to 0. Register contents are then re-zeroed by the sequence. No partial write completes on the edge after reset assertion.
- Width rules: no arithmetic on data. clr_cnt is AW bits wide, and no wrap occurs because the state leaves CLEAR at NREG-1.
- No X on any output at any time after reset assertion.

Test Plan:
- Release `rst_n` with rs1_addr=5, rs2_addr=31 -> ready=0 for edges 1..30, ready=1 after edge 31; rs1_data=0 and rs2_data=0 throughout CLEAR and on the first RUN read.
- During CLEAR drive rd_we=1, rd_addr=3, rd_data=0xDEADBEEF -> after ready, a read of addr 3 returns 0x00000000.
- RUN: write 0xFFFFFFFF to x7, then read rs1=7, rs2=0 -> next edge rs1_data=0xFFFFFFFF, rs2_data=0. Write 0x12345678 to x0, read x0 -> 0.
- Same-edge bypass: rd_we=1, rd_addr=9, rd_data=0xA5A5A5A5 with x9 previously 0x1 and rs1_addr=rs2_addr=9 -> that edge yields both outputs 0xA5A5A5A5. The following edge with rd_we=0 still yields 0xA5A5A5A5.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31, then read pairs (i, 32-i) -> both values match for every i.
- Assert `rst_n` mid-RUN, between edges, with x7=0xFFFFFFFF -> ready, rs1_data and rs2_data go 0 immediately without a clock edge. After 31 edges ready=1, and reading x7 returns 0.
